// File: rtl/sevenseg_reader.sv
// Recovers hex digits from a multiplexed active-low seven-segment bus by
// qualifying each strobe/pattern pair for stability and decoding it back to a nibble.
module sevenseg_reader #(
  parameter int NDIGITS = 4,
  parameter int STABLE  = 4
) (
  input  logic                   clock,
  input  logic                   n_reset,
  input  logic [6:0]             seg,
  input  logic [NDIGITS-1:0]     anode,
  output logic [4*NDIGITS-1:0]   value,
  output logic [NDIGITS-1:0]     digit_ok,
  output logic                   frame_valid,
  output logic                   error
);

  localparam logic [7:0] STABLE_C = 8'(STABLE);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t             state, state_next;
  logic [6:0]         seg_q, hold_seg;
  logic [NDIGITS-1:0] an_q, hold_an, mask, cap_bit;
  logic [7:0]         count, count_next;
  logic               load_hold, capture_next, capture_q;
  logic               legal, match;
  logic               dec_valid, dec_blank;
  logic [3:0]         dec_nib;

  assign legal   = $onehot(~an_q);
  assign match   = (an_q == hold_an) && (seg_q == hold_seg);
  assign cap_bit = ~hold_an;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      seg_q     <= 7'h7f;
      an_q      <= '1;
      hold_seg  <= 7'h7f;
      hold_an   <= '1;
      count     <= 8'd0;
      state     <= IDLE;
      capture_q <= 1'b0;
    end else begin
      seg_q     <= seg;
      an_q      <= anode;
      count     <= count_next;
      state     <= state_next;
      capture_q <= capture_next;
      if (load_hold) begin
        hold_seg <= seg_q;
        hold_an  <= an_q;
      end
    end
  end

  // Capture is requested once the pair has held STABLE samples, then performed one edge later.
  always_comb begin
    state_next   = state;
    count_next   = count;
    load_hold    = 1'b0;
    capture_next = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          load_hold  = 1'b1;
          count_next = 8'd1;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (!legal) begin
          count_next = 8'd0;
          state_next = IDLE;
        end else if (!match) begin
          load_hold  = 1'b1;
          count_next = 8'd1;
        end else if (count >= STABLE_C) begin
          capture_next = 1'b1;
          state_next   = HELD;
        end else begin
          count_next = count + 8'd1;
        end
      end
      HELD: begin
        if (!legal) begin
          count_next = 8'd0;
          state_next = IDLE;
        end else if (!match) begin
          load_hold  = 1'b1;
          count_next = 8'd1;
          state_next = SETTLE;
        end
      end
      default: begin
        count_next = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    dec_valid = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (hold_seg)
      7'b1000000: dec_nib = 4'h0;
      7'b1111001: dec_nib = 4'h1;
      7'b0100100: dec_nib = 4'h2;
      7'b0110000: dec_nib = 4'h3;
      7'b0011001: dec_nib = 4'h4;
      7'b0010010: dec_nib = 4'h5;
      7'b0000010: dec_nib = 4'h6;
      7'b1111000: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0010000: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b0000011: dec_nib = 4'hB;
      7'b1000110: dec_nib = 4'hC;
      7'b0100001: dec_nib = 4'hD;
      7'b0000110: dec_nib = 4'hE;
      7'b0001110: dec_nib = 4'hF;
      7'b1111111: begin
        dec_valid = 1'b0;
        dec_blank = 1'b1;
      end
      default:    dec_valid = 1'b0;
    endcase
  end

  // A frame completes when a valid capture fills the mask; the mask restarts empty.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      value       <= '0;
      digit_ok    <= '0;
      mask        <= '0;
      frame_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      error       <= 1'b0;
      if (capture_q) begin
        if (dec_valid) begin
          for (int i = 0; i < NDIGITS; i++) begin
            if (cap_bit[i]) value[4*i +: 4] <= dec_nib;
          end
          digit_ok <= digit_ok | cap_bit;
          if ((mask | cap_bit) == '1) begin
            frame_valid <= 1'b1;
            mask        <= '0;
          end else begin
            mask <= mask | cap_bit;
          end
        end else if (dec_blank) begin
          digit_ok <= digit_ok & ~cap_bit;
        end else begin
          digit_ok <= digit_ok & ~cap_bit;
          mask     <= mask & ~cap_bit;
          error    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_reader.sv
// Directed bench for sevenseg_reader: drives strobe/pattern sequences and
// checks decoded words, digit_ok, frame and error pulses against hand-computed values.
module tb_sevenseg_reader;

  logic        clock;
  logic        n_reset;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic [15:0] value;
  logic [3:0]  digit_ok;
  logic        frame_valid;
  logic        error;

  int          checks = 0;
  int          errors = 0;
  int          fvCount = 0;
  int          errCount = 0;
  int          fvBase;
  int          errBase;
  logic [15:0] fvValue = '0;
  logic        seen8 = 1'b0;

  localparam logic [6:0] BLANK = 7'b1111111;

  sevenseg_reader #(.NDIGITS(4), .STABLE(4)) dut (
    .clock(clock), .n_reset(n_reset), .seg(seg), .anode(anode),
    .value(value), .digit_ok(digit_ok), .frame_valid(frame_valid), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulses are counted on the falling edge so each one-cycle pulse is seen exactly once.
  always @(negedge clock) begin
    if (frame_valid) begin
      fvCount++;
      fvValue = value;
    end
    if (error) errCount++;
    if (value[7:4] == 4'h8) seen8 = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] an, input logic [6:0] sg, input int n);
    anode = an;
    seg   = sg;
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic showDigit(input logic [3:0] an, input logic [6:0] sg);
    applyStimulus(an, sg, 6);
    applyStimulus(4'b1111, BLANK, 2);
  endtask

  initial begin
    n_reset = 1'b0;
    anode   = 4'b1111;
    seg     = BLANK;
    repeat (2) @(negedge clock);
    checkOutput("reset_value", value, 0);
    checkOutput("reset_digit_ok", digit_ok, 0);
    checkOutput("reset_frame_valid", frame_valid, 0);
    checkOutput("reset_error", error, 0);
    n_reset = 1'b1;
    @(negedge clock);

    applyStimulus(4'b1110, 7'b1111001, 6);
    checkOutput("latency_before_edge6", digit_ok, 0);
    applyStimulus(4'b1110, 7'b1111001, 1);
    checkOutput("latency_digit_ok", digit_ok, 4'b0001);
    checkOutput("latency_value", value, 16'h0001);
    applyStimulus(4'b1110, 7'b1111001, 3);
    applyStimulus(4'b1111, BLANK, 2);
    checkOutput("single_value", value, 16'h0001);
    checkOutput("single_error", errCount, 0);
    checkOutput("single_frame", fvCount, 0);

    fvBase = fvCount;
    showDigit(4'b1110, 7'b0110000);
    showDigit(4'b1101, 7'b0001000);
    showDigit(4'b1011, 7'b1000110);
    checkOutput("scan_no_early_frame", fvCount - fvBase, 0);
    showDigit(4'b0111, 7'b0001110);
    checkOutput("scan_frame_once", fvCount - fvBase, 1);
    checkOutput("scan_frame_value", fvValue, 16'hFCA3);
    checkOutput("scan_value", value, 16'hFCA3);
    checkOutput("scan_digit_ok", digit_ok, 4'b1111);

    applyStimulus(4'b1101, 7'b1111001, 1);
    applyStimulus(4'b1101, 7'b0000000, 2);
    applyStimulus(4'b1101, 7'b1111001, 5);
    applyStimulus(4'b1111, BLANK, 2);
    checkOutput("glitch_nibble1", value[7:4], 4'h1);
    checkOutput("glitch_never8", seen8, 0);

    fvBase  = fvCount;
    errBase = errCount;
    showDigit(4'b1011, 7'b0100100);
    checkOutput("d2_valid_value", value, 16'hF213);
    showDigit(4'b1011, 7'b1010101);
    checkOutput("bad_error_once", errCount - errBase, 1);
    checkOutput("bad_digit_ok", digit_ok, 4'b1011);
    checkOutput("bad_value_kept", value, 16'hF213);
    showDigit(4'b1110, 7'b0010010);
    showDigit(4'b0111, 7'b0000110);
    checkOutput("mask_cleared_no_frame", fvCount - fvBase, 0);
    checkOutput("pre_blank_value", value, 16'hE215);
    showDigit(4'b1110, BLANK);
    checkOutput("blank_digit_ok", digit_ok, 4'b1010);
    checkOutput("blank_value_kept", value[3:0], 4'h5);
    checkOutput("blank_no_error", errCount - errBase, 1);
    applyStimulus(4'b1100, 7'b1111000, 8);
    applyStimulus(4'b1111, BLANK, 2);
    checkOutput("multilow_value", value, 16'hE215);
    checkOutput("multilow_digit_ok", digit_ok, 4'b1010);
    showDigit(4'b1011, 7'b1111000);
    checkOutput("refill_frame_once", fvCount - fvBase, 1);
    checkOutput("refill_frame_value", fvValue, 16'hE715);
    checkOutput("refill_digit_ok", digit_ok, 4'b1110);

    showDigit(4'b1110, 7'b0000000);
    showDigit(4'b1101, 7'b0010000);
    showDigit(4'b1011, 7'b0000011);
    checkOutput("prereset_value", value, 16'hEB98);
    n_reset = 1'b0;
    #1;
    checkOutput("midreset_value", value, 0);
    checkOutput("midreset_digit_ok", digit_ok, 0);
    checkOutput("midreset_flags", {frame_valid, error}, 0);
    @(negedge clock);
    n_reset = 1'b1;
    @(negedge clock);

    fvBase = fvCount;
    showDigit(4'b0111, 7'b0011001);
    showDigit(4'b1110, 7'b1111001);
    showDigit(4'b1101, 7'b0100100);
    checkOutput("postreset_no_early_frame", fvCount - fvBase, 0);
    showDigit(4'b1011, 7'b0110000);
    checkOutput("postreset_frame_once", fvCount - fvBase, 1);
    checkOutput("postreset_value", value, 16'h4321);
    checkOutput("postreset_digit_ok", digit_ok, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_reader.md
Name: sevenseg_reader

Overview:
- Receive-side counterpart of the seven-segment decoder.
- Observes a multiplexed, active-low seven-segment display bus (segment lines plus active-low digit strobes) and recovers the hex value shown on each digit.
- Qualifies each pattern by stability, decodes it back to a 4-bit nibble, and assembles a multi-digit word.
- Used as a display monitor/self-check block and as the scoreboard front end in display-path benches.

Parameters:
- NDIGITS, 4: number of multiplexed digits; anode width and number of nibbles in value.
- STABLE, 4: consecutive sampled cycles a strobe/pattern pair must hold before capture; legal range 1..255.

Ports:
- clock  input  1  system clock, rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- seg  input  7  active-low segments, bit order {g,f,e,d,c,b,a}.
- anode  input  NDIGITS  active-low digit strobes; bit i selects digit i.
- value  output  4*NDIGITS  decoded nibbles; digit i at value[4i+3:4i].
- digit_ok  output  NDIGITS  bit i set while nibble i holds a validly decoded pattern.
- frame_valid  output  1  one-cycle pulse when every digit has been validly captured since the last pulse.
- error  output  1  one-cycle pulse on capture of an undecodable, non-blank pattern.

Behaviour:
- Reset (async, n_reset=0): value=0, digit_ok=0, frame_valid=0, error=0, capture mask=0, stability count=0, state=IDLE.
- Input stage: seg and anode are registered once (seg_q, an_q) before any use. No combinational path from inputs to outputs.
- Strobe legality: an_q is legal only when exactly one bit is 0. All-ones (blanking interval) and multi-low are illegal.
- FSM states and transitions:
  - IDLE: an_q illegal -> stay. an_q legal -> load hold registers {an_q,seg_q}, count=1, go SETTLE.
  - SETTLE: {an_q,seg_q} equals hold -> count+1. Differs but legal -> reload hold, count=1. Illegal -> IDLE, count=0. When count reaches STABLE -> capture on the next edge, go HELD.
  - HELD: stay while {an_q,seg_q} equals hold; no re-capture. Differs but legal -> reload, count=1, SETTLE. Illegal -> IDLE.
- Latency: with inputs constant from before edge 0, capture effects are visible after edge STABLE+2. For STABLE=4, that is edge 6.
- Decode table (active-low gfedcba -> nibble):
  - 0: 1000000; 1: 1111001; 2: 0100100; 3: 0110000
  - 4: 0011001; 5: 0010010; 6: 0000010; 7: 1111000
  - 8: 0000000; 9: 0010000; A: 0001000; b: 0000011
  - C: 1000110; d: 0100001; E: 0000110; F: 0001110
- Capture of digit i (i = index of low bit in hold anode):
  - Valid pattern: write nibble i, set digit_ok[i], set mask[i].
  - Blank (1111111): nibble i unchanged, clear digit_ok[i], mask[i] unchanged, no error.
  - Any other pattern: nibble i unchanged, clear digit_ok[i], clear mask[i], pulse error.
- Frame completion: if a valid capture makes mask all ones, frame_valid pulses on that same edge and mask clears to 0.
  - Repeat captures of one digit keep mask[i] set and never pulse frame_valid early.
- Glitches: any change in seg or anode shorter than STABLE sampled cycles never causes a capture.
- Count saturates at STABLE; no wrap while HELD.
- Reset mid-SETTLE or mid-frame: everything clears immediately; the next frame starts with an empty mask.

Test Plan:
- Reset, then anode=4'b1110, seg=1111001 held 10 cycles -> after edge 6, value=16'h0001, digit_ok=4'b0001, single capture, error=0, frame_valid=0.
- Scan digits 0..3 with patterns 3,A,C,F, each held 6 cycles with a 2-cycle anode=1111 gap -> value=16'hFCA3, digit_ok=4'b1111, frame_valid pulses exactly once, on the digit-3 capture edge.
- Digit 1 seg=1111001 with a 2-cycle glitch to 0000000 inside an 8-cycle hold (STABLE=4) -> nibble 1 = 1, never 8.
- Digit 2 seg=1010101 held 6 cycles -> error pulses once, digit_ok[2]=0, nibble 2 unchanged, mask[2] cleared so the next frame needs digit 2 again.
- Digit 0 blank 1111111 after a valid 5 -> digit_ok[0]=0, value[3:0] stays 5, error=0. anode=4'b1100 held -> no capture.
- Assert n_reset low for 1 cycle mid-frame after 3 of 4 digits captured -> all outputs 0 immediately; a following full 4-digit scan gives exactly one frame_valid.
